// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and read-pipeline depth for the
// convolution feature-map double buffer.
package conv_pkg;

  localparam int CONV_DATA_WIDTH   = 27;
  localparam int CONV_ADDR_WIDTH   = 10;
  localparam int CONV_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_bank_ram.sv
// One feature-map bank: a single write port plus two read ports with registered outputs.
// Storage is never reset; only the read data registers are cleared.
module conv_bank_ram #(
  parameter int DATA_WIDTH = 27,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] write_address_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic [ADDR_WIDTH-1:0] read_address_0_in,
  input  logic [ADDR_WIDTH-1:0] read_address_1_in,
  output logic [DATA_WIDTH-1:0] read_data_0_out,
  output logic [DATA_WIDTH-1:0] read_data_1_out
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_0_q;
  logic [DATA_WIDTH-1:0] rd_1_q;

  always_ff @(posedge clk) begin
    if (we_in) begin
      mem_q[write_address_in] <= write_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_0_q <= '0;
      rd_1_q <= '0;
    end else begin
      rd_0_q <= mem_q[read_address_0_in];
      rd_1_q <= mem_q[read_address_1_in];
    end
  end

  assign read_data_0_out = rd_0_q;
  assign read_data_1_out = rd_1_q;

endmodule

// File: rtl/conv_fmap_buffer.sv
// Ping-pong feature-map buffer: engine reads one bank (2-cycle latency) while results fill the other.
// Define CONV_BUF_ZERO_PAD_EN to make reads beyond LAYER_WIDTH*LAYER_HEIGHT return zero.
module conv_fmap_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = CONV_DATA_WIDTH,
  parameter int ADDR_WIDTH   = CONV_ADDR_WIDTH,
  parameter int LAYER_WIDTH  = 12,
  parameter int LAYER_HEIGHT = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_in,
  input  logic [ADDR_WIDTH-1:0] read_address_0_in,
  input  logic [ADDR_WIDTH-1:0] read_address_1_in,
  output logic [DATA_WIDTH-1:0] data_0_out,
  output logic [DATA_WIDTH-1:0] data_1_out,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [ADDR_WIDTH-1:0] write_address_in,
  input  logic                  we_in,
  input  logic                  conv_done_in,
  output logic                  bank_sel_out,
  output logic                  buf_ready_out,
  output logic [ADDR_WIDTH:0]   write_count_out,
  output logic                  err_out
);

  localparam logic [ADDR_WIDTH:0] WCNT_MAX = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  conv_state_e           state_q;
  logic                  drain_cnt_q;
  logic                  bank_sel_q;
  logic                  buf_ready_q;
  logic [ADDR_WIDTH:0]   wcnt_q;
  logic                  err_q;

  logic                  wr_ok;
  logic                  we_a;
  logic                  we_b;

  // Read pipeline: stage 1 holds the address and the bank it was issued against,
  // so reads already in flight at a swap still complete from the old bank.
  logic [ADDR_WIDTH-1:0] raddr_0_q;
  logic [ADDR_WIDTH-1:0] raddr_1_q;
  logic                  rsel_1_q;
  logic                  rsel_2_q;
  logic                  pad_0_1_q, pad_1_1_q;
  logic                  pad_0_2_q, pad_1_2_q;
  logic                  pad_0_d, pad_1_d;

  logic [DATA_WIDTH-1:0] a_rd_0, a_rd_1, b_rd_0, b_rd_1;

`ifdef CONV_BUF_ZERO_PAD_EN
  localparam logic [ADDR_WIDTH:0] PAD_LIMIT = (ADDR_WIDTH+1)'(LAYER_WIDTH * LAYER_HEIGHT);
  assign pad_0_d = ({1'b0, read_address_0_in} >= PAD_LIMIT);
  assign pad_1_d = ({1'b0, read_address_1_in} >= PAD_LIMIT);
`else
  assign pad_0_d = 1'b0;
  assign pad_1_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      raddr_0_q <= '0;
      raddr_1_q <= '0;
      rsel_1_q  <= 1'b0;
      rsel_2_q  <= 1'b0;
      pad_0_1_q <= 1'b0;
      pad_1_1_q <= 1'b0;
      pad_0_2_q <= 1'b0;
      pad_1_2_q <= 1'b0;
    end else begin
      raddr_0_q <= read_address_0_in;
      raddr_1_q <= read_address_1_in;
      rsel_1_q  <= bank_sel_q;
      rsel_2_q  <= rsel_1_q;
      pad_0_1_q <= pad_0_d;
      pad_1_1_q <= pad_1_d;
      pad_0_2_q <= pad_0_1_q;
      pad_1_2_q <= pad_1_1_q;
    end
  end

  // Writes land only in the bank not currently selected for reading.
  assign wr_ok = we_in && (state_q == ACTIVE || state_q == DRAIN);
  assign we_a  = wr_ok && bank_sel_q;
  assign we_b  = wr_ok && !bank_sel_q;

  conv_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_a (
    .clk               (clk),
    .reset             (reset),
    .we_in             (we_a),
    .write_address_in  (write_address_in),
    .write_data_in     (result_in),
    .read_address_0_in (raddr_0_q),
    .read_address_1_in (raddr_1_q),
    .read_data_0_out   (a_rd_0),
    .read_data_1_out   (a_rd_1)
  );

  conv_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_b (
    .clk               (clk),
    .reset             (reset),
    .we_in             (we_b),
    .write_address_in  (write_address_in),
    .write_data_in     (result_in),
    .read_address_0_in (raddr_0_q),
    .read_address_1_in (raddr_1_q),
    .read_data_0_out   (b_rd_0),
    .read_data_1_out   (b_rd_1)
  );

  assign data_0_out = pad_0_2_q ? '0 : (rsel_2_q ? b_rd_0 : a_rd_0);
  assign data_1_out = pad_1_2_q ? '0 : (rsel_2_q ? b_rd_1 : a_rd_1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
      bank_sel_q  <= 1'b0;
      buf_ready_q <= 1'b0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (conv_done_in || we_in) begin
            err_q <= 1'b1;
          end
          if (run_in) begin
            state_q <= ACTIVE;
            wcnt_q  <= '0;
          end
        end
        ACTIVE: begin
          if (run_in) begin
            err_q <= 1'b1;
          end
          if (we_in && wcnt_q != WCNT_MAX) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
          if (conv_done_in) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (run_in || conv_done_in) begin
            err_q <= 1'b1;
          end
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q     <= IDLE;
            bank_sel_q  <= !bank_sel_q;
            buf_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bank_sel_out    = bank_sel_q;
  assign buf_ready_out   = buf_ready_q;
  assign write_count_out = wcnt_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_conv_fmap_buffer.sv
// Directed bench for conv_fmap_buffer: reset, latency, full layer swap, errors, mid-layer reset.
module tb_conv_fmap_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_in;
  logic [9:0]  read_address_0_in;
  logic [9:0]  read_address_1_in;
  logic [26:0] data_0_out;
  logic [26:0] data_1_out;
  logic [26:0] result_in;
  logic [9:0]  write_address_in;
  logic        we_in;
  logic        conv_done_in;
  logic        bank_sel_out;
  logic        buf_ready_out;
  logic [10:0] write_count_out;
  logic        err_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_fmap_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .run_in            (run_in),
    .read_address_0_in (read_address_0_in),
    .read_address_1_in (read_address_1_in),
    .data_0_out        (data_0_out),
    .data_1_out        (data_1_out),
    .result_in         (result_in),
    .write_address_in  (write_address_in),
    .we_in             (we_in),
    .conv_done_in      (conv_done_in),
    .bank_sel_out      (bank_sel_out),
    .buf_ready_out     (buf_ready_out),
    .write_count_out   (write_count_out),
    .err_out           (err_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   32'(bank_sel_out), 32'd0);
    check({tag, "_rdy"},   32'(buf_ready_out), 32'd0);
    check({tag, "_wcnt"},  32'(write_count_out), 32'd0);
    check({tag, "_err"},   32'(err_out), 32'd0);
    check({tag, "_d0"},    32'(data_0_out), 32'd0);
    check({tag, "_d1"},    32'(data_1_out), 32'd0);
  endtask

  logic [31:0] pad_exp;

  initial begin
    reset = 1'b0; run_in = 1'b0; we_in = 1'b0; conv_done_in = 1'b0;
    read_address_0_in = '0; read_address_1_in = '0;
    result_in = '0; write_address_in = '0;
`ifdef CONV_BUF_ZERO_PAD_EN
    pad_exp = 32'd0;
`else
    pad_exp = 32'h07FFFFFF;
`endif
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Layer 1: 144 writes into bank B, conv_done on the last write.
    run_in = 1'b1; tick(); run_in = 1'b0;
    check("l1_wcnt_clr", 32'(write_count_out), 32'd0);
    for (int k = 0; k < 144; k++) begin
      we_in = 1'b1; write_address_in = 10'(k); result_in = 27'(k + 1);
      conv_done_in = (k == 143);
      tick();
    end
    conv_done_in = 1'b0;
    check("l1_wcnt_144", 32'(write_count_out), 32'd144);
    check("l1_sel_d1", 32'(bank_sel_out), 32'd0);
    // Write during drain is stored but not counted.
    write_address_in = 10'd144; result_in = 27'h7FFFFFF;
    tick();
    we_in = 1'b0;
    check("l1_sel_d2", 32'(bank_sel_out), 32'd0);
    check("l1_rdy_early", 32'(buf_ready_out), 32'd0);
    tick();
    check("l1_sel_swap", 32'(bank_sel_out), 32'd1);
    check("l1_rdy", 32'(buf_ready_out), 32'd1);
    check("l1_wcnt_drain", 32'(write_count_out), 32'd144);
    tick();
    check("l1_rdy_once", 32'(buf_ready_out), 32'd0);
    read_address_0_in = 10'd143; read_address_1_in = 10'd5;
    tick(); tick();
    check("l1_rd143", 32'(data_0_out), 32'd144);
    check("l1_rd5", 32'(data_1_out), 32'd6);
    read_address_0_in = 10'd144;
    tick(); tick();
    check("l1_rd144_pad", 32'(data_0_out), pad_exp);
    check("l1_err_none", 32'(err_out), 32'd0);

    // Layer 2: fill bank A addresses 5 and 6, swap back to A.
    run_in = 1'b1; tick(); run_in = 1'b0;
    check("l2_wcnt_clr", 32'(write_count_out), 32'd0);
    we_in = 1'b1; write_address_in = 10'd5; result_in = 27'h0000123; tick();
    write_address_in = 10'd6; result_in = 27'h0000456; conv_done_in = 1'b1; tick();
    we_in = 1'b0; conv_done_in = 1'b0;
    tick(); tick();
    check("l2_sel_swap", 32'(bank_sel_out), 32'd0);
    check("l2_rdy", 32'(buf_ready_out), 32'd1);

    // Read latency: address 5 presented in cycle N, visible only in N+2.
    read_address_0_in = 10'd6;
    tick(); tick(); tick();
    check("lat_pre", 32'(data_0_out), 32'h456);
    read_address_0_in = 10'd5;
    tick();
    check("lat_n1", 32'(data_0_out), 32'h456);
    tick();
    check("lat_n2", 32'(data_0_out), 32'h123);

    // conv_done while idle: error, no swap.
    conv_done_in = 1'b1; tick(); conv_done_in = 1'b0;
    check("idle_done_err", 32'(err_out), 32'd1);
    tick(); tick(); tick();
    check("idle_done_sel", 32'(bank_sel_out), 32'd0);
    check("idle_done_rdy", 32'(buf_ready_out), 32'd0);
    reset = 1'b0; tick(); reset = 1'b1;
    check("rst2_err", 32'(err_out), 32'd0);

    // Layer 3: run_in during drain is ignored but flagged.
    run_in = 1'b1; tick(); run_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      we_in = 1'b1; write_address_in = 10'(300 + k); result_in = 27'(k);
      conv_done_in = (k == 2);
      tick();
    end
    we_in = 1'b0; conv_done_in = 1'b0;
    run_in = 1'b1; tick(); run_in = 1'b0;
    check("drain_run_err", 32'(err_out), 32'd1);
    tick();
    check("drain_run_sel", 32'(bank_sel_out), 32'd1);
    check("drain_run_rdy", 32'(buf_ready_out), 32'd1);
    check("drain_run_wcnt", 32'(write_count_out), 32'd3);

    // Reset mid-layer after 50 writes into bank B.
    reset = 1'b0; tick(); reset = 1'b1;
    read_address_0_in = 10'd5; read_address_1_in = 10'd6;
    run_in = 1'b1; tick(); run_in = 1'b0;
    for (int k = 0; k < 50; k++) begin
      we_in = 1'b1; write_address_in = 10'(200 + k); result_in = 27'(1000 + k);
      tick();
    end
    we_in = 1'b0;
    check("mid_wcnt50", 32'(write_count_out), 32'd50);
    check("mid_d0_pre", 32'(data_0_out), 32'h123);
    reset = 1'b0; tick(); reset = 1'b1;
    check_reset_outputs("mid_rst");

    // Empty layer to swap to bank B and confirm retained data.
    run_in = 1'b1; tick(); run_in = 1'b0;
    conv_done_in = 1'b1; tick(); conv_done_in = 1'b0;
    tick(); tick();
    check("ret_sel", 32'(bank_sel_out), 32'd1);
    read_address_0_in = 10'd200; read_address_1_in = 10'd249;
    tick(); tick();
    check("ret_rd200", 32'(data_0_out), 32'd1000);
    check("ret_rd249", 32'(data_1_out), 32'd1049);
    check("ret_err", 32'(err_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_fmap_buffer.md
CONV_FMAP_BUFFER -- requirements
Module: conv_fmap_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 27, feature-map word width.
REQ-002 Parameter ADDR_WIDTH, default 10, word address width per bank.
REQ-003 Parameter LAYER_WIDTH, default 12, pixels per row.
REQ-004 Parameter LAYER_HEIGHT, default 12, rows per layer.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-low reset.
REQ-007 Port run_in  input  1  one-cycle pulse marking layer start; mirrors the engine's run.
REQ-008 Port read_address_0_in, read_address_1_in  input  ADDR_WIDTH  engine read requests.
REQ-009 Port data_0_out, data_1_out  output  DATA_WIDTH  read data for the matching address.
REQ-010 Port result_in  input  DATA_WIDTH  engine result word.
REQ-011 Port write_address_in  input  ADDR_WIDTH  result address.
REQ-012 Port we_in  input  1  result write enable.
REQ-013 Port conv_done_in  input  1  one-cycle pulse marking layer end.
REQ-014 Port bank_sel_out  output  1  current read bank; 0 = bank A.
REQ-015 Port buf_ready_out  output  1  one-cycle pulse after a bank swap completes.
REQ-016 Port write_count_out  output  ADDR_WIDTH+1  writes accepted in the current layer.
REQ-017 Port err_out  output  1  sticky protocol-error flag.

Function
REQ-018 Two banks of 2^ADDR_WIDTH words: the read bank is selected by bank_sel_out; the write bank is the other one.
REQ-019 Read latency is exactly 2 cycles: address registered in cycle N, data registered in N+1, valid on the outputs in N+2; both ports are independent and fully pipelined.
REQ-020 A write with we_in=1 in cycle N stores result_in at write_address_in in the write bank at the edge ending cycle N; a read of the write bank is never possible.
REQ-021 States: IDLE, ACTIVE, DRAIN.
REQ-022 IDLE -> ACTIVE on run_in; write_count_out clears to 0 on the same edge.
REQ-023 ACTIVE: each we_in=1 increments write_count_out, saturating at 2^ADDR_WIDTH.
REQ-024 ACTIVE -> DRAIN on conv_done_in; a write in the same cycle is accepted and counted.
REQ-025 DRAIN lasts exactly 2 cycles; reads in flight finish from the old read bank; on its final edge bank_sel_out toggles, buf_ready_out pulses in the next cycle, and the FSM returns to IDLE.
REQ-026 err_out sets on: run_in outside IDLE; conv_done_in outside ACTIVE; we_in outside ACTIVE or DRAIN; the offending write is dropped and the run_in or conv_done_in is ignored.
REQ-027 Simultaneous run_in and conv_done_in in IDLE: run_in is taken and err_out sets.
REQ-028 Memory contents are not reset.

Reset
REQ-029 With reset=0 at a clock edge: FSM=IDLE, bank_sel_out=0, buf_ready_out=0, write_count_out=0, err_out=0, data_0_out=data_1_out=0, and the read pipeline is flushed.
REQ-030 Reset mid-layer abandons the layer with no swap; the bank contents are unchanged.

Configuration
REQ-031 Macro CONV_BUF_ZERO_PAD_EN defined: any read address >= LAYER_WIDTH*LAYER_HEIGHT returns 0 with the same 2-cycle latency, giving implicit padding.
REQ-032 Macro not defined: every address reads the raw bank word, so out-of-range addresses read stored memory.

Structure
REQ-033 Package conv_pkg holds the DATA_WIDTH and ADDR_WIDTH defaults, the state enum (IDLE/ACTIVE/DRAIN) and the read-latency constant (2).
REQ-034 Sub-module conv_bank_ram: one bank with two registered-output read ports and one write port, instantiated twice.

Verification
REQ-035 Preload bank A address 5 = 27'h0000123; read_address_0_in=5 in cycle 10 -> data_0_out=27'h0000123 in cycle 12, not before.
REQ-036 run_in, then 144 writes (address k, data k+1), then conv_done_in -> write_count_out=144, bank_sel_out=1 two cycles after DRAIN entry, buf_ready_out pulses once, and a read of address 143 returns 144.
REQ-037 we_in and conv_done_in together on the 144th write -> write counted and stored, and the swap still occurs.
REQ-038 conv_done_in while IDLE -> err_out=1 with no swap; run_in during DRAIN -> ignored, err_out=1.
REQ-039 With CONV_BUF_ZERO_PAD_EN, a read of address 144 (containing 27'h7FFFFFF) -> 0; without the macro -> 27'h7FFFFFF.
REQ-040 reset=0 for one cycle in ACTIVE after 50 writes -> all outputs take their reset values, bank_sel_out stays 0, and the written data is retained.
